// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data arbiter in front of one shared single-port RAM.
// Define MEM_ARB_CLEAR_EN to zero the whole RAM after reset before accepting requests.
module mem_port_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             ready,
  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);
  logic last;
  logic ready_next;
  logic clearing;
  logic [AW-1:0] clr_addr;
  // last = 1 means data won most recently, so fetch wins the next conflict
  assign i_gnt = ready & i_req & (~d_req | last);
  assign d_gnt = ready & d_req & (~i_req | ~last);
`ifdef MEM_ARB_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_next;
  logic [AW-1:0] cnt, cnt_next;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
    end
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    if (state == CLEAR) begin
      cnt_next = cnt + 1'b1;
      state_next = (cnt == AW'(DEPTH - 1)) ? RUN : CLEAR;
    end
  end
  // the reset gate keeps mem_we low while reset_n is held
  assign clearing = reset_n & (state == CLEAR);
  assign clr_addr = cnt;
  assign ready_next = (state_next == RUN);
`else
  assign clearing = 1'b0;
  assign clr_addr = '0;
  assign ready_next = 1'b1;
`endif
  assign mem_we = clearing | (d_gnt & d_we);
  assign mem_addr = clearing ? clr_addr : i_gnt ? i_addr : d_gnt ? d_addr : '0;
  assign mem_wdata = d_gnt ? d_wdata : '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ready <= 1'b0;
      last <= 1'b1;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      ready <= ready_next;
      if (i_gnt | d_gnt) last <= d_gnt;
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt & ~d_we;
      if (i_gnt) i_rdata <= mem_rdata;
      if (d_gnt & ~d_we) d_rdata <= mem_rdata;
    end
endmodule
